div_res_station: RTL and testbench
==================================

Name: div_res_station

Overview:
- Reservation station feeding the sequential divider: buffers dispatched DIV/DIVU/REM/REMU ops and snoops the CDB for source-operand wakeup.
- Issues the oldest ready op when the divider reports ready, driving the divider's select strobe and register-file read indices.
- Sits between rename/dispatch and the divider execute unit.

Parameters:
- NUM_ENTRIES, 4, station depth (≥2).
- PREG_BITS, 6, physical register index width.
- ROB_BITS, 5, ROB index width.
- STARTUP_CYCLES, 3, cycles after rst deassertion during which issue is inhibited.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  pipeline flush; clears all entries
- dispatch_valid  in  1  new op offered
- dispatch_ready  out  1  station can accept (not full)
- dispatch_ps1 / dispatch_ps2  in  PREG_BITS  source physical regs
- dispatch_ps1_rdy / dispatch_ps2_rdy  in  1  source already available
- dispatch_pd  in  PREG_BITS  destination physical reg
- dispatch_rd  in  5  architectural destination
- dispatch_rob  in  ROB_BITS  ROB index
- dispatch_funct3  in  3  divide funct3 (bit2 always 1)
- dispatch_pc  in  32  instruction PC
- cdb_valid  in  1  CDB broadcast valid
- cdb_pd  in  PREG_BITS  broadcast physical reg
- div_ready  in  1  divider idle and accepting
- issue_valid  out  1  select strobe to divider (one cycle per op)
- issue_ps1 / issue_ps2  out  PREG_BITS  regfile read indices
- issue_pd, issue_rd, issue_rob, issue_funct3, issue_pc  out  as dispatch  issued op fields
- count  out  $clog2(NUM_ENTRIES+1)  occupied entries

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - All entries invalid, count=0, startup counter=0.
  - Outputs during rst: dispatch_ready=0, issue_valid=0, all issue_* fields 0.
- Storage is a compacting queue: entry 0 is oldest, and valid entries are always contiguous from index 0.
- Entry ready = valid & ps1_rdy & ps2_rdy, using registered ready bits.
- Issue (combinational):
  - issue_valid=1 iff div_ready & !flush & startup done & some entry is ready.
  - Selects the lowest-index ready entry; issue_* show its fields.
  - When issue_valid=0, issue_* fields are 0.
- Issued entry is removed at the next edge. Higher entries shift down by one, preserving order.
- Startup: counter increments each cycle after rst deasserts until it reaches STARTUP_CYCLES. Issue is inhibited while counter < STARTUP_CYCLES. Dispatch is allowed from the first cycle after reset.
- Dispatch:
  - dispatch_ready = !rst & (count != NUM_ENTRIES). It is not relaxed by a same-cycle issue.
  - Accepted when dispatch_valid & dispatch_ready & !flush.
  - Written to slot count−(issue_valid?1:0), i.e. the first free slot after compaction.
- Wakeup: when cdb_valid, every valid entry with ps1==cdb_pd (resp. ps2) sets ps1_rdy (resp. ps2_rdy) at the edge.
  - A same-cycle dispatch whose source matches cdb_pd is captured with that ready bit set (bypass).
  - An entry woken this cycle is not issue-eligible until the next cycle.
  - An entry issuing this cycle ignores wakeup.
- count is updated at each edge: count + accept − issue.
- Simultaneous dispatch + issue: count unchanged and ordering preserved; the new entry lands at the tail.
- Flush: highest priority. Next state has all entries invalid and count=0. Same-cycle issue_valid is forced 0 and any same-cycle dispatch is dropped. Startup counter is unaffected.
- rst mid-operation: all state is discarded at that edge, and the startup inhibit restarts.
- div_ready is low for many cycles while the divider is busy; entries simply wait. The station never asserts issue_valid while div_ready=0.

Test Plan:
- Reset/startup: rst high 2 cycles, then dispatch an op with both ready at cycle 0 after reset, div_ready=1 → dispatch_ready=1 at cycle 0; issue_valid stays 0 for cycles 0–2 and goes to 1 at cycle 3 with the dispatched pd/rob.
- Ordering: dispatch A(rob=1, ps1 not ready), B(rob=2), C(rob=3), both ready → issues B then C on successive div_ready windows. Then cdb_pd=A.ps1 → A issues the following cycle; count ends at 0.
- Full: dispatch 4 ops with unready sources → count=4 and dispatch_ready=0; a fifth dispatch_valid is ignored. Wake one entry and let it issue → dispatch_ready=1 the next cycle.
- Bypass: dispatch with ps2=7 not ready while cdb_valid=1 and cdb_pd=7 → entry is captured ready; issue_valid=1 on the next cycle.
- Simultaneous dispatch+issue at count=2 → count stays 2; the new op sits at index 1 behind the surviving older entry.
- Flush with 3 entries while issue would fire and dispatch_valid=1 → issue_valid=0 that cycle; count=0 and no issue next cycle.

Source files
------------

// File: rtl/div_res_station.sv
// Reservation station for the sequential divider: holds DIV/DIVU/REM/REMU ops until sources wake via the CDB.
// Latency: an op dispatched with ready sources can issue the cycle after dispatch; a CDB wakeup makes it eligible the cycle after.
// Backpressure: dispatch_ready drops when the station is full; ops wait in order while div_ready is low.
module div_res_station #(
  parameter int NUM_ENTRIES    = 4,
  parameter int PREG_BITS      = 6,
  parameter int ROB_BITS       = 5,
  parameter int STARTUP_CYCLES = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 dispatch_valid,
  output logic                                 dispatch_ready,
  input  logic [PREG_BITS-1:0]                 dispatch_ps1,
  input  logic [PREG_BITS-1:0]                 dispatch_ps2,
  input  logic                                 dispatch_ps1_rdy,
  input  logic                                 dispatch_ps2_rdy,
  input  logic [PREG_BITS-1:0]                 dispatch_pd,
  input  logic [4:0]                           dispatch_rd,
  input  logic [ROB_BITS-1:0]                  dispatch_rob,
  input  logic [2:0]                           dispatch_funct3,
  input  logic [31:0]                          dispatch_pc,
  input  logic                                 cdb_valid,
  input  logic [PREG_BITS-1:0]                 cdb_pd,
  input  logic                                 div_ready,
  output logic                                 issue_valid,
  output logic [PREG_BITS-1:0]                 issue_ps1,
  output logic [PREG_BITS-1:0]                 issue_ps2,
  output logic [PREG_BITS-1:0]                 issue_pd,
  output logic [4:0]                           issue_rd,
  output logic [ROB_BITS-1:0]                  issue_rob,
  output logic [2:0]                           issue_funct3,
  output logic [31:0]                          issue_pc,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]     count
);

  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int SW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;

  typedef struct packed {
    logic [PREG_BITS-1:0] ps1;
    logic [PREG_BITS-1:0] ps2;
    logic                 ps1_rdy;
    logic                 ps2_rdy;
    logic [PREG_BITS-1:0] pd;
    logic [4:0]           rd;
    logic [ROB_BITS-1:0]  rob;
    logic [2:0]           funct3;
    logic [31:0]          pc;
  } entry_t;

  // Entry i is valid iff i < count_q: the queue is kept compacted from index 0 (oldest).
  entry_t                ent_q [NUM_ENTRIES];
  entry_t                ent_w [NUM_ENTRIES];
  entry_t                ent_d [NUM_ENTRIES];
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         start_q, start_d;
  logic                  startup_done;
  logic [NUM_ENTRIES-1:0] rdy_vec;
  logic                  any_rdy;
  logic [IW-1:0]         sel;
  entry_t                sel_ent;
  entry_t                new_ent;
  logic                  accept;
  logic [CW-1:0]         wr_slot;

  // Startup inhibit: count up to STARTUP_CYCLES after reset, then hold.
  always_comb begin
    startup_done = (start_q >= SW'(STARTUP_CYCLES));
    start_d      = startup_done ? start_q : start_q + SW'(1);
  end

  // Issue eligibility uses only registered ready bits, so a same-cycle wakeup cannot issue yet.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rdy_vec[i] = (CW'(i) < count_q) && ent_q[i].ps1_rdy && ent_q[i].ps2_rdy;
    end
  end

  // Oldest-first select: lowest ready index wins.
  always_comb begin
    any_rdy = 1'b0;
    sel     = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (rdy_vec[i]) begin
        any_rdy = 1'b1;
        sel     = IW'(i);
      end
    end
  end

  assign sel_ent = ent_q[sel];

  // Issue strobe and fields; fields are zeroed whenever nothing issues.
  always_comb begin
    issue_valid  = !rst && div_ready && !flush && startup_done && any_rdy;
    issue_ps1    = '0;
    issue_ps2    = '0;
    issue_pd     = '0;
    issue_rd     = '0;
    issue_rob    = '0;
    issue_funct3 = '0;
    issue_pc     = '0;
    if (issue_valid) begin
      issue_ps1    = sel_ent.ps1;
      issue_ps2    = sel_ent.ps2;
      issue_pd     = sel_ent.pd;
      issue_rd     = sel_ent.rd;
      issue_rob    = sel_ent.rob;
      issue_funct3 = sel_ent.funct3;
      issue_pc     = sel_ent.pc;
    end
  end

  // Dispatch acceptance; the new op goes to the first free slot after this cycle's compaction.
  always_comb begin
    dispatch_ready = !rst && (count_q != CW'(NUM_ENTRIES));
    accept         = dispatch_valid && dispatch_ready && !flush;
    wr_slot        = count_q - CW'(issue_valid);
    new_ent.ps1     = dispatch_ps1;
    new_ent.ps2     = dispatch_ps2;
    new_ent.ps1_rdy = dispatch_ps1_rdy || (cdb_valid && (cdb_pd == dispatch_ps1));
    new_ent.ps2_rdy = dispatch_ps2_rdy || (cdb_valid && (cdb_pd == dispatch_ps2));
    new_ent.pd      = dispatch_pd;
    new_ent.rd      = dispatch_rd;
    new_ent.rob     = dispatch_rob;
    new_ent.funct3  = dispatch_funct3;
    new_ent.pc      = dispatch_pc;
  end

  // CDB snoop: set matching source-ready bits in every valid entry.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_w[i] = ent_q[i];
      if (cdb_valid && (CW'(i) < count_q)) begin
        if (ent_q[i].ps1 == cdb_pd) ent_w[i].ps1_rdy = 1'b1;
        if (ent_q[i].ps2 == cdb_pd) ent_w[i].ps2_rdy = 1'b1;
      end
    end
  end

  // Next state: remove the issued entry by shifting the younger ones down, then append the new op.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_w[i];
    end
    if (issue_valid) begin
      for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
        if (IW'(i) >= sel) ent_d[i] = ent_w[i+1];
      end
    end
    if (accept) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (CW'(i) == wr_slot) ent_d[i] = new_ent;
      end
    end
    count_d = count_q + CW'(accept) - CW'(issue_valid);
    // Flush empties the queue; stale slot contents are masked by count and overwritten on dispatch.
    if (flush) count_d = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      start_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      start_q <= start_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_div_res_station.sv
// Directed bench for div_res_station: per-cycle vectors of inputs and expected outputs.
module tb_div_res_station;

  logic        clk = 1'b0;
  logic        rst, flush, dispatch_valid, dispatch_ready;
  logic [5:0]  dispatch_ps1, dispatch_ps2, dispatch_pd;
  logic        dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic [4:0]  dispatch_rd, dispatch_rob;
  logic [2:0]  dispatch_funct3;
  logic [31:0] dispatch_pc;
  logic        cdb_valid;
  logic [5:0]  cdb_pd;
  logic        div_ready, issue_valid;
  logic [5:0]  issue_ps1, issue_ps2, issue_pd;
  logic [4:0]  issue_rd, issue_rob;
  logic [2:0]  issue_funct3;
  logic [31:0] issue_pc;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_res_station #(
    .NUM_ENTRIES(4), .PREG_BITS(6), .ROB_BITS(5), .STARTUP_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_pd(dispatch_pd), .dispatch_rd(dispatch_rd), .dispatch_rob(dispatch_rob),
    .dispatch_funct3(dispatch_funct3), .dispatch_pc(dispatch_pc),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .div_ready(div_ready),
    .issue_valid(issue_valid), .issue_ps1(issue_ps1), .issue_ps2(issue_ps2),
    .issue_pd(issue_pd), .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_funct3(issue_funct3), .issue_pc(issue_pc), .count(count)
  );

  typedef struct {
    logic       rst, flush, dv;
    logic [5:0] ps1;
    logic       r1;
    logic [5:0] ps2;
    logic       r2;
    logic [4:0] rob;
    logic       cv;
    logic [5:0] cpd;
    logic       dr;
    logic       e_drdy, e_iv;
    logic [4:0] e_rob;
    logic [2:0] e_cnt;
    logic       k_cnt;
  } vec_t;

  vec_t vq[$];
  int   vidx = 0;

  function automatic vec_t mk(input int rst_, input int fl, input int dv, input int ps1, input int r1,
                              input int ps2, input int r2, input int rob, input int cv, input int cpd,
                              input int dr, input int edr, input int eiv, input int erob,
                              input int ecnt, input int kc);
    vec_t v;
    v.rst = 1'(rst_); v.flush = 1'(fl); v.dv = 1'(dv);
    v.ps1 = 6'(ps1); v.r1 = 1'(r1); v.ps2 = 6'(ps2); v.r2 = 1'(r2);
    v.rob = 5'(rob); v.cv = 1'(cv); v.cpd = 6'(cpd); v.dr = 1'(dr);
    v.e_drdy = 1'(edr); v.e_iv = 1'(eiv); v.e_rob = 5'(erob);
    v.e_cnt = 3'(ecnt); v.k_cnt = 1'(kc);
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp_v);
    end
  endtask

  // Drive one cycle of inputs at negedge, then compare outputs mid-cycle before the posedge.
  task automatic apply(input vec_t v);
    logic [31:0] exp_pd, exp_pc;
    @(negedge clk);
    rst              = v.rst;
    flush            = v.flush;
    dispatch_valid   = v.dv;
    dispatch_ps1     = v.ps1;
    dispatch_ps1_rdy = v.r1;
    dispatch_ps2     = v.ps2;
    dispatch_ps2_rdy = v.r2;
    dispatch_rob     = v.rob;
    dispatch_pd      = 6'(v.rob) + 6'd32;
    dispatch_rd      = v.rob;
    dispatch_funct3  = {1'b1, v.rob[1:0]};
    dispatch_pc      = 32'h1000 + {25'd0, v.rob, 2'b00};
    cdb_valid        = v.cv;
    cdb_pd           = v.cpd;
    div_ready        = v.dr;
    #2;
    exp_pd = v.e_iv ? 32'(v.e_rob) + 32'd32 : 32'd0;
    exp_pc = v.e_iv ? 32'h1000 + 32'(v.e_rob) * 4 : 32'd0;
    check("dispatch_ready", vidx, 32'(dispatch_ready), 32'(v.e_drdy));
    check("issue_valid",    vidx, 32'(issue_valid),    32'(v.e_iv));
    check("issue_rob",      vidx, 32'(issue_rob),      v.e_iv ? 32'(v.e_rob) : 32'd0);
    check("issue_pd",       vidx, 32'(issue_pd),       exp_pd);
    check("issue_pc",       vidx, issue_pc,            exp_pc);
    if (v.k_cnt) check("count", vidx, 32'(count), 32'(v.e_cnt));
    vidx++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
    dispatch_ps1 = '0; dispatch_ps2 = '0; dispatch_ps1_rdy = 1'b0; dispatch_ps2_rdy = 1'b0;
    dispatch_pd = '0; dispatch_rd = '0; dispatch_rob = '0; dispatch_funct3 = '0; dispatch_pc = '0;
    cdb_valid = 1'b0; cdb_pd = '0; div_ready = 1'b0;

    //                rst fl dv ps1 r1 ps2 r2 rob cv cpd dr   drdy iv rob cnt kc
    // Reset, then startup inhibit for three cycles.
    vq.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0, 0,  0, 0, 0));
    vq.push_back(mk(1, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0, 0,  0, 0, 1));
    vq.push_back(mk(0, 0, 1,  1, 1,  2, 1,  5, 0,  0, 1,   1, 0,  0, 0, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1,  5, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 0, 1));
    // Ordering: A waits on ps1=10, B and C issue first, then CDB wakes A.
    vq.push_back(mk(0, 0, 1, 10, 0, 11, 1,  1, 0,  0, 0,   1, 0,  0, 0, 1));
    vq.push_back(mk(0, 0, 1, 12, 1, 13, 1,  2, 0,  0, 0,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 1, 14, 1, 15, 1,  3, 0,  0, 0,   1, 0,  0, 2, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0,   1, 0,  0, 3, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1,  2, 3, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0,   1, 0,  0, 2, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1,  3, 2, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 10, 1,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1,  1, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 0, 1));
    // Full: four blocked ops, fifth offer ignored, wake rob 10 and issue it.
    vq.push_back(mk(0, 0, 1, 20, 0, 24, 1,  8, 0,  0, 1,   1, 0,  0, 0, 1));
    vq.push_back(mk(0, 0, 1, 21, 0, 24, 1,  9, 0,  0, 1,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 1, 22, 0, 24, 1, 10, 0,  0, 1,   1, 0,  0, 2, 1));
    vq.push_back(mk(0, 0, 1, 23, 0, 24, 1, 11, 0,  0, 1,   1, 0,  0, 3, 1));
    vq.push_back(mk(0, 0, 1, 25, 1, 26, 1, 12, 0,  0, 1,   0, 0,  0, 4, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 22, 1,   0, 0,  0, 4, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0, 1, 10, 4, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 3, 1));
    // Flush with 3 entries while rob 9 would issue and a dispatch is offered.
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 21, 1,   1, 0,  0, 3, 1));
    vq.push_back(mk(0, 1, 1, 30, 1, 31, 1, 13, 0,  0, 1,   1, 0,  0, 3, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 0, 1));
    // Bypass: ps2=7 becomes ready via same-cycle CDB broadcast.
    vq.push_back(mk(0, 0, 1,  5, 1,  7, 0, 14, 1,  7, 1,   1, 0,  0, 0, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1, 14, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 0, 1));
    // Dispatch + issue at count=2: F must land behind D; one CDB wakes both.
    vq.push_back(mk(0, 0, 1, 40, 0, 41, 1, 16, 0,  0, 0,   1, 0,  0, 0, 1));
    vq.push_back(mk(0, 0, 1, 42, 1, 43, 1, 17, 0,  0, 0,   1, 0,  0, 1, 1));
    vq.push_back(mk(0, 0, 1, 40, 0, 45, 1, 18, 0,  0, 1,   1, 1, 17, 2, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 1, 40, 0,   1, 0,  0, 2, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1, 16, 2, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1, 18, 1, 1));
    vq.push_back(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 0, 1));

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i]);
    end

    // Mid-operation reset: pending op discarded and the startup inhibit restarts.
    apply(mk(0, 0, 1,  1, 1,  2, 1, 20, 0,  0, 0,   1, 0,  0, 0, 1));
    apply(mk(1, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   0, 0,  0, 1, 1));
    apply(mk(0, 0, 1,  3, 1,  4, 1, 21, 0,  0, 1,   1, 0,  0, 0, 1));
    apply(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 1, 1));
    apply(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 1, 1));
    apply(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 1, 21, 1, 1));
    apply(mk(0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 1,   1, 0,  0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
